// File: rtl/ind_lookup_stage.sv
// Indirection-table stage: maps CAM match addresses to action-RAM addresses. Lookup is 3 cycles to phv_valid_out
// with valid/ready backpressure. Control beats are never stalled: owned packets write the table, all others are forwarded 2 cycles late.
module ind_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_vld_i,
   input  logic [W-1:0]  push_dat_i,
   input  logic          pop_rdy_i,
   output logic          pop_vld_o,
   output logic [W-1:0]  pop_dat_o,
   output logic [CW-1:0] count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          push, pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop       = pop_vld_o && pop_rdy_i;
   assign push      = push_vld_i && ((count_q != CW'(DEPTH)) || pop);
   assign pop_vld_o = (count_q != '0);
   assign pop_dat_o = pop_vld_o ? mem_q[rd_ptr_q] : '0;
   assign count_o   = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= nxt(wr_ptr_q);
         if (pop)  rd_ptr_q <= nxt(rd_ptr_q);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_dat_i;
   end
endmodule

module ind_lookup_stage #(
   parameter int               C_S_AXIS_DATA_WIDTH  = 256,
   parameter int               C_S_AXIS_TUSER_WIDTH = 128,
   parameter int               PHV_LEN              = 4*8*64+256,
   parameter int               STAGE_ID             = 0,
   parameter int               INDIRECTION_ID       = 6,
   parameter int               SUB_UNIT_ID          = 1,
   parameter int               ADDR_W               = 11,
   parameter int               IND_W                = 8,
   parameter logic [IND_W-1:0] MISS_VAL             = {IND_W{1'b1}},
   parameter int               OUT_FIFO_DEPTH       = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [PHV_LEN-1:0]                phv_in,
   input  logic [ADDR_W-1:0]                 match_addr_in,
   input  logic                              if_match_in,
   input  logic                              phv_valid_in,
   output logic                              ready_out,
   output logic [PHV_LEN-1:0]                phv_out,
   output logic [IND_W-1:0]                  ind_addr_out,
   output logic                              if_match_out,
   output logic                              phv_valid_out,
   input  logic                              ready_in,
   output logic [31:0]                       hit_cnt,
   output logic [31:0]                       miss_cnt,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
   input  logic                              c_s_axis_tvalid,
   input  logic                              c_s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
   output logic                              c_m_axis_tvalid,
   output logic                              c_m_axis_tlast
);
   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;
   localparam int KW = DW / 8;
   localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);
   localparam int OW = CW + 2;
   localparam int FW = PHV_LEN + 1 + IND_W;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   typedef enum logic [1:0] {IDLE_C, PARSE_C, IND_ENTRY, FLUSH_REST_C} ctl_st_t;

   // ---------------- lookup pipeline ----------------
   logic               rdy_en_q;
   logic               s1_vld_q, s1_hit_q, s2_vld_q, s2_hit_q;
   logic [ADDR_W-1:0]  s1_addr_q;
   logic [PHV_LEN-1:0] s1_phv_q, s2_phv_q;
   logic [IND_W-1:0]   tbl_q [2**ADDR_W];
   logic [IND_W-1:0]   rd_dat_q;
   logic [31:0]        hit_cnt_q, miss_cnt_q;
   logic [CW-1:0]      fifo_cnt;
   logic [OW-1:0]      occ;
   logic [FW-1:0]      fifo_dat;
   logic               accept;

   logic               wr_vld_q;
   logic [ADDR_W-1:0]  wr_addr_q, idx_q;
   logic [IND_W-1:0]   wr_dat_q, entry;

   // Counting in-flight stages as well as FIFO entries reserves a slot for every accepted PHV.
   assign occ       = OW'(fifo_cnt) + OW'(s1_vld_q) + OW'(s2_vld_q);
   assign ready_out = rdy_en_q && (occ < OW'(OUT_FIFO_DEPTH));
   assign accept    = phv_valid_in && ready_out;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q   <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_hit_q   <= 1'b0;
         s1_addr_q  <= '0;
         s1_phv_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_hit_q   <= 1'b0;
         s2_phv_q   <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         s1_vld_q <= accept;
         if (accept) begin
            s1_hit_q  <= if_match_in;
            s1_addr_q <= match_addr_in;
            s1_phv_q  <= phv_in;
            if (if_match_in) begin
               if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else if (miss_cnt_q != '1) begin
               miss_cnt_q <= miss_cnt_q + 1'b1;
            end
         end
         s2_vld_q <= s1_vld_q;
         s2_hit_q <= s1_hit_q;
         s2_phv_q <= s1_phv_q;
      end
   end

   // Table write lands one cycle after its beat; a read of the same address that cycle sees the new entry.
   always_ff @(posedge clk) begin
      if (wr_vld_q) tbl_q[wr_addr_q] <= wr_dat_q;
      rd_dat_q <= (wr_vld_q && (wr_addr_q == s1_addr_q)) ? wr_dat_q : tbl_q[s1_addr_q];
   end

   ind_fifo #(.W(FW), .DEPTH(OUT_FIFO_DEPTH)) u_out_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_vld_i (s2_vld_q),
      .push_dat_i ({s2_phv_q, s2_hit_q, s2_hit_q ? rd_dat_q : MISS_VAL}),
      .pop_rdy_i  (ready_in),
      .pop_vld_o  (phv_valid_out),
      .pop_dat_o  (fifo_dat),
      .count_o    (fifo_cnt)
   );

   assign {phv_out, if_match_out, ind_addr_out} = fifo_dat;

   // ---------------- control path ----------------
   ctl_st_t st_q;
   beat_t   in_beat, buf_q, dly_q, out_q;
   logic    fwd_q, out_vld_q, owned;

   assign in_beat = '{data: c_s_axis_tdata, user: c_s_axis_tuser, keep: c_s_axis_tkeep, last: c_s_axis_tlast};
   assign owned   = (c_s_axis_tdata[115 +: 5] == 5'(STAGE_ID))
                 && (c_s_axis_tdata[112 +: 3] == 3'(INDIRECTION_ID))
                 && (c_s_axis_tdata[124 +: 4] == 4'(SUB_UNIT_ID))
                 && (c_s_axis_tdata[64 +: 16] == 16'hf2f1)
                 && (c_s_axis_tdata[120 +: 4] != 4'd0);

   // Entry = low IND_W bits of the top word of the byte-reversed beat, i.e. bytes 3..0 of tdata in reverse.
   always_comb begin
      entry = '0;
      for (int b = 0; b < IND_W; b++) entry[b] = c_s_axis_tdata[8*(3 - b/8) + b%8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= IDLE_C;
         buf_q     <= '0;
         dly_q     <= '0;
         out_q     <= '0;
         fwd_q     <= 1'b0;
         out_vld_q <= 1'b0;
         idx_q     <= '0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_dat_q  <= '0;
      end else begin
         dly_q     <= in_beat;
         fwd_q     <= 1'b0;
         wr_vld_q  <= 1'b0;
         out_vld_q <= fwd_q;
         out_q     <= fwd_q ? dly_q : '0;
         case (st_q)
            IDLE_C: begin
               if (c_s_axis_tvalid) begin
                  buf_q <= in_beat;
                  st_q  <= PARSE_C;
               end
            end
            PARSE_C: begin
               if (buf_q.last) begin
                  out_vld_q <= 1'b1;
                  out_q     <= buf_q;
                  if (c_s_axis_tvalid) buf_q <= in_beat;
                  st_q <= c_s_axis_tvalid ? PARSE_C : IDLE_C;
               end else if (c_s_axis_tvalid) begin
                  if (owned) begin
                     idx_q <= c_s_axis_tdata[128 +: ADDR_W];
                     st_q  <= c_s_axis_tlast ? IDLE_C : IND_ENTRY;
                  end else begin
                     out_vld_q <= 1'b1;
                     out_q     <= buf_q;
                     fwd_q     <= 1'b1;
                     st_q      <= c_s_axis_tlast ? IDLE_C : FLUSH_REST_C;
                  end
               end
            end
            IND_ENTRY: begin
               if (c_s_axis_tvalid) begin
                  wr_vld_q  <= 1'b1;
                  wr_addr_q <= idx_q;
                  wr_dat_q  <= entry;
                  idx_q     <= idx_q + 1'b1;
                  if (c_s_axis_tlast) st_q <= IDLE_C;
               end
            end
            FLUSH_REST_C: begin
               if (c_s_axis_tvalid) begin
                  fwd_q <= 1'b1;
                  if (c_s_axis_tlast) st_q <= IDLE_C;
               end
            end
            default: st_q <= IDLE_C;
         endcase
      end
   end

   assign c_m_axis_tvalid = out_vld_q;
   assign c_m_axis_tdata  = out_q.data;
   assign c_m_axis_tuser  = out_q.user;
   assign c_m_axis_tkeep  = out_q.keep;
   assign c_m_axis_tlast  = out_q.last;
endmodule
